// File: rtl/ps2_keycode_source_if.sv
// rtl/ps2_keycode_source_if.sv - decoded key stream bundle between the PS/2 source and its consumers
interface ps2_keycode_source_if;
    logic [7:0] keycode;
    logic       key_event;
    logic       key_release;
    logic       frame_err;

    modport master (output keycode, output key_event, output key_release, output frame_err);
    modport slave  (input  keycode, input  key_event, input  key_release, input  frame_err);
endinterface

// File: rtl/ps2_keycode_source.sv
// rtl/ps2_keycode_source.sv - PS/2 set-2 receiver and held-key decoder (optional PS2_ARROW_KEYS_EN)
module ps2_keycode_source #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        PS2_CLK,
    input  logic                        PS2_DAT,
    ps2_keycode_source_if.master        key_if
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          fall_q, fall_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic          ext_q, ext_d, brk_q, brk_d;
    logic [7:0]    keycode_q, keycode_d;
    logic          key_event_q, key_event_d;
    logic          key_release_q, key_release_d;
    logic          frame_err_q, frame_err_d;
    logic          timeout, byte_ok, byte_bad;
    logic [7:0]    mapped;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            clk_s1_q      <= 1'b1;
            clk_s2_q      <= 1'b1;
            dat_s1_q      <= 1'b1;
            dat_s2_q      <= 1'b1;
            filt_q        <= 1'b1;
            filt_cnt_q    <= '0;
            fall_q        <= 1'b0;
            to_cnt_q      <= '0;
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            par_q         <= 1'b0;
            ext_q         <= 1'b0;
            brk_q         <= 1'b0;
            keycode_q     <= '0;
            key_event_q   <= 1'b0;
            key_release_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            clk_s1_q      <= PS2_CLK;
            clk_s2_q      <= clk_s1_q;
            dat_s1_q      <= PS2_DAT;
            dat_s2_q      <= dat_s1_q;
            filt_q        <= filt_d;
            filt_cnt_q    <= filt_cnt_d;
            fall_q        <= fall_d;
            to_cnt_q      <= to_cnt_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            par_q         <= par_d;
            ext_q         <= ext_d;
            brk_q         <= brk_d;
            keycode_q     <= keycode_d;
            key_event_q   <= key_event_d;
            key_release_q <= key_release_d;
            frame_err_q   <= frame_err_d;
        end
    end

    // A new clock level is accepted only after it has differed from the filtered level FILTER_LEN cycles in a row.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) filt_d = clk_s2_q;
            else                                   filt_cnt_d = filt_cnt_q + 1'b1;
        end
        fall_d = filt_q & ~filt_d;

        to_cnt_d = to_cnt_q;
        if (fall_q || state_q == IDLE)          to_cnt_d = '0;
        else if (to_cnt_q != TW'(TIMEOUT_CYCLES)) to_cnt_d = to_cnt_q + 1'b1;
    end

    assign timeout  = (state_q != IDLE) && !fall_q && (to_cnt_q == TW'(TIMEOUT_CYCLES));
    assign byte_ok  = fall_q && (state_q == STOP) && dat_s2_q && (^{shift_q, par_q});
    assign byte_bad = (fall_q && (state_q == STOP) && !(dat_s2_q && (^{shift_q, par_q}))) || timeout;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        if (timeout) begin
            state_d = IDLE;
        end else if (fall_q) begin
            case (state_q)
                IDLE: begin
                    if (!dat_s2_q) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = dat_s2_q;
                    state_d = STOP;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        mapped = '0;
        if (!ext_q) begin
            case (shift_q)
                8'h1D:   mapped = 8'd26;
                8'h1C:   mapped = 8'd4;
                8'h1B:   mapped = 8'd22;
                8'h23:   mapped = 8'd7;
                8'h5A:   mapped = 8'd40;
                8'h29:   mapped = 8'd44;
                default: mapped = '0;
            endcase
        end
`ifdef PS2_ARROW_KEYS_EN
        else begin
            case (shift_q)
                8'h75:   mapped = 8'd26;
                8'h6B:   mapped = 8'd4;
                8'h72:   mapped = 8'd22;
                8'h74:   mapped = 8'd7;
                default: mapped = '0;
            endcase
        end
`endif
    end

    // Prefix bytes only arm flags; any other good byte consumes both flags whether mapped or not.
    always_comb begin
        keycode_d     = keycode_q;
        key_event_d   = 1'b0;
        key_release_d = key_release_q;
        frame_err_d   = 1'b0;
        ext_d         = ext_q;
        brk_d         = brk_q;
        if (byte_bad) begin
            frame_err_d = 1'b1;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
        end else if (byte_ok) begin
            if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (mapped != 8'd0) begin
                    key_event_d   = 1'b1;
                    key_release_d = brk_q;
                    if (!brk_q)                  keycode_d = mapped;
                    else if (keycode_q == mapped) keycode_d = '0;
                end
            end
        end
    end

    assign key_if.keycode     = keycode_q;
    assign key_if.key_event   = key_event_q;
    assign key_if.key_release = key_release_q;
    assign key_if.frame_err   = frame_err_q;

endmodule

// File: tb/tb_ps2_keycode_source.sv
// tb/tb_ps2_keycode_source.sv - self-checking bench for ps2_keycode_source
module tb_ps2_keycode_source;
    localparam int FL   = 4;
    localparam int TO   = 400;
    localparam int HALF = 25;

    logic Clk = 1'b0;
    logic Reset, PS2_CLK, PS2_DAT;

    ps2_keycode_source_if key_if ();

    ps2_keycode_source #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .PS2_CLK (PS2_CLK),
        .PS2_DAT (PS2_DAT),
        .key_if  (key_if)
    );

    always #5 Clk = ~Clk;

    int n_chk  = 0;
    int n_pass = 0;
    int ev_cnt = 0;
    int err_cnt = 0;
    int last_rel = 0;

    always @(negedge Clk) begin
        if (key_if.key_event === 1'b1) begin
            ev_cnt++;
            last_rel = int'(key_if.key_release);
        end
        if (key_if.frame_err === 1'b1) err_cnt++;
    end

    typedef struct {
        logic [7:0] code;
        bit         flip;
        bit         bad_stop;
        int         kc;
        int         ev;
        int         rel;
        int         err;
    } vec_t;

    vec_t vt[$];

    int kmap[int];
    int m_kc;
    bit m_ext, m_brk;

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic wait_clk(int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic ps2_bit(logic b);
        PS2_DAT = b;
        wait_clk(HALF / 2);
        PS2_CLK = 1'b0;
        wait_clk(HALF);
        PS2_CLK = 1'b1;
        wait_clk(HALF - HALF / 2);
    endtask

    task automatic send_frame(logic [7:0] code, bit flip, bit bad_stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(code[i]);
        ps2_bit((~^code) ^ flip);
        ps2_bit(~bad_stop);
        PS2_DAT = 1'b1;
        wait_clk(4);
    endtask

    task automatic frame_check(string nm, logic [7:0] code, bit flip, bit bad_stop,
                               int kc, int ev, int rel, int err);
        int e0, r0;
        e0 = ev_cnt;
        r0 = err_cnt;
        send_frame(code, flip, bad_stop);
        chk({nm, ".keycode"}, int'(key_if.keycode), kc);
        chk({nm, ".events"}, ev_cnt - e0, ev);
        if (ev > 0) chk({nm, ".release"}, last_rel, rel);
        chk({nm, ".errors"}, err_cnt - r0, err);
    endtask

    function automatic void add(logic [7:0] c, bit f, bit bs, int kc, int ev, int rel, int err);
        vec_t v;
        v.code = c; v.flip = f; v.bad_stop = bs;
        v.kc = kc; v.ev = ev; v.rel = rel; v.err = err;
        vt.push_back(v);
    endfunction

    initial begin
        logic [7:0] codes [6];
        logic [7:0] c23;
        int e0, r0, exp_ev, exp_rel, exp_err, key;
        bit flip;

        codes[0] = 8'h1D; codes[1] = 8'h1C; codes[2] = 8'h1B;
        codes[3] = 8'h23; codes[4] = 8'h75; codes[5] = 8'h15;

        kmap[8'h1D] = 26; kmap[8'h1C] = 4; kmap[8'h1B] = 22;
        kmap[8'h23] = 7;  kmap[8'h5A] = 40; kmap[8'h29] = 44;
`ifdef PS2_ARROW_KEYS_EN
        kmap[256 + 8'h75] = 26; kmap[256 + 8'h6B] = 4;
        kmap[256 + 8'h72] = 22; kmap[256 + 8'h74] = 7;
`endif

        add(8'h1D, 0, 0, 26, 1, 0, 0);
        add(8'hF0, 0, 0, 26, 0, 0, 0);
        add(8'h1D, 0, 0,  0, 1, 1, 0);
        add(8'h1C, 0, 0,  4, 1, 0, 0);
        add(8'h23, 0, 0,  7, 1, 0, 0);
        add(8'hF0, 0, 0,  7, 0, 0, 0);
        add(8'h1C, 0, 0,  7, 1, 1, 0);
        add(8'h1B, 1, 0,  7, 0, 0, 1);
        add(8'h5A, 0, 0, 40, 1, 0, 0);
        add(8'hF0, 0, 0, 40, 0, 0, 0);
        add(8'h5A, 0, 0,  0, 1, 1, 0);
        add(8'hE0, 0, 0,  0, 0, 0, 0);
`ifdef PS2_ARROW_KEYS_EN
        add(8'h75, 0, 0, 26, 1, 0, 0);
        add(8'hE0, 0, 0, 26, 0, 0, 0);
        add(8'hF0, 0, 0, 26, 0, 0, 0);
        add(8'h75, 0, 0,  0, 1, 1, 0);
`else
        add(8'h75, 0, 0,  0, 0, 0, 0);
        add(8'hE0, 0, 0,  0, 0, 0, 0);
        add(8'hF0, 0, 0,  0, 0, 0, 0);
        add(8'h75, 0, 0,  0, 0, 0, 0);
`endif
        add(8'h15, 0, 0,  0, 0, 0, 0);
        add(8'h29, 0, 0, 44, 1, 0, 0);
        add(8'h29, 0, 0, 44, 1, 0, 0);
        add(8'h1D, 0, 1, 44, 0, 0, 1);
        add(8'hF0, 0, 0, 44, 0, 0, 0);
        add(8'h1D, 1, 0, 44, 0, 0, 1);
        add(8'h1D, 0, 0, 26, 1, 0, 0);

        Reset = 1'b0;
        PS2_CLK = 1'b1;
        PS2_DAT = 1'b1;
        wait_clk(5);
        chk("reset.keycode", int'(key_if.keycode), 0);
        chk("reset.key_event", int'(key_if.key_event), 0);
        chk("reset.key_release", int'(key_if.key_release), 0);
        chk("reset.frame_err", int'(key_if.frame_err), 0);
        Reset = 1'b1;
        wait_clk(20);

        for (int i = 0; i < vt.size(); i++)
            frame_check($sformatf("vec%0d", i), vt[i].code, vt[i].flip, vt[i].bad_stop,
                        vt[i].kc, vt[i].ev, vt[i].rel, vt[i].err);

        // stall after the fourth data bit long enough to trip the timeout
        e0 = ev_cnt; r0 = err_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        wait_clk(TO + 50);
        chk("timeout.errors", err_cnt - r0, 1);
        chk("timeout.events", ev_cnt - e0, 0);
        chk("timeout.keycode", int'(key_if.keycode), 26);
        frame_check("after_timeout", 8'h1B, 0, 0, 22, 1, 0, 0);

        e0 = ev_cnt; r0 = err_cnt;
        ps2_bit(1'b1);
        wait_clk(TO + 50);
        chk("glitch.errors", err_cnt - r0, 0);
        chk("glitch.keycode", int'(key_if.keycode), 22);
        frame_check("glitch_then_frame", 8'h23, 0, 0, 7, 1, 0, 0);

        frame_check("brk_prefix", 8'hF0, 0, 0, 7, 0, 0, 0);
        frame_check("brk_other", 8'h1C, 0, 0, 7, 1, 1, 0);

        c23 = 8'h23;
        e0 = ev_cnt; r0 = err_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(c23[i]);
        PS2_DAT = c23[4];
        wait_clk(HALF / 2);
        PS2_CLK = 1'b0;
        wait_clk(10);
        Reset = 1'b0;
        #1;
        chk("midreset.keycode", int'(key_if.keycode), 0);
        chk("midreset.key_event", int'(key_if.key_event), 0);
        chk("midreset.key_release", int'(key_if.key_release), 0);
        chk("midreset.frame_err", int'(key_if.frame_err), 0);
        wait_clk(3);
        PS2_CLK = 1'b1;
        PS2_DAT = 1'b1;
        wait_clk(3);
        Reset = 1'b1;
        wait_clk(TO + 50);
        chk("midreset.no_err", err_cnt - r0, 0);
        chk("midreset.no_event", ev_cnt - e0, 0);
        frame_check("after_reset", 8'h23, 0, 0, 7, 1, 0, 0);

        m_kc = 7; m_ext = 0; m_brk = 0;
        for (int n = 0; n < 40; n++) begin
            int r;
            logic [7:0] code;
            r = int'($urandom_range(0, 9));
            if (r == 0)      code = 8'hE0;
            else if (r < 3)  code = 8'hF0;
            else if (r < 8)  code = codes[$urandom_range(0, 5)];
            else             code = 8'($urandom_range(0, 255));
            flip = ($urandom_range(0, 9) == 0);
            exp_ev = 0; exp_rel = 0; exp_err = 0;
            if (flip) begin
                exp_err = 1; m_ext = 0; m_brk = 0;
            end else if (code == 8'hE0) begin
                m_ext = 1;
            end else if (code == 8'hF0) begin
                m_brk = 1;
            end else begin
                key = (m_ext ? 256 : 0) + int'(code);
                if (kmap.exists(key)) begin
                    exp_ev = 1;
                    exp_rel = m_brk ? 1 : 0;
                    if (!m_brk)                m_kc = kmap[key];
                    else if (m_kc == kmap[key]) m_kc = 0;
                end
                m_ext = 0; m_brk = 0;
            end
            frame_check($sformatf("rnd%0d_%02h", n, code), code, flip, 0, m_kc, exp_ev, exp_rel, exp_err);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ps2_keycode_source.md
# ps2_keycode_source

Receives PS/2 set-2 scan codes from the keyboard port and turns them into the 8-bit HID-style `keycode` that the sprite movement logic consumes. The movement logic expects these codes: W=26, A=4, S=22, D=7. The block handles the serial frame, make/break/extended prefixes, and a held-key register. It sits between the board PS/2 pins and every `keycode` consumer in the game top level.

## Interface
Parameters:
- `FILTER_LEN`, default 8: number of consecutive `Clk` cycles the synchronized PS/2 clock must hold a new level before that level is accepted.
- `TIMEOUT_CYCLES`, default 50000: maximum number of `Clk` cycles allowed between accepted PS/2 falling edges inside a frame (1 ms at 50 MHz).

Ports:
- `Clk` in 1: system clock, 50 MHz.
- `Reset` in 1: one clock; reset is asynchronous and active-low.
- `PS2_CLK` in 1: keyboard clock, asynchronous, idles high.
- `PS2_DAT` in 1: keyboard data, asynchronous.
- `keycode` out 8: currently held mapped key; 0 when no key is held.
- `key_event` out 1: one-cycle pulse on each decoded mapped make or break.
- `key_release` out 1: qualifies `key_event`; 1 = break, 0 = make.
- `frame_err` out 1: one-cycle pulse on a parity, stop or timeout error.

## Operation
Input conditioning:
- `PS2_CLK` and `PS2_DAT` each pass through a 2-flop synchronizer.
- The synchronized clock then passes through the `FILTER_LEN` stability filter.
- A falling edge of the filtered clock produces a one-cycle `fall` strobe. Data is sampled on `fall`.

Frame FSM (states IDLE, DATA, PARITY, STOP):
- IDLE: on `fall` with data=0, go to DATA with bit count = 0. On `fall` with data=1, stay in IDLE; this is a glitch and raises no error.
- DATA: shift data in LSB first. After the 8th bit, go to PARITY.
- PARITY: capture the parity bit and go to STOP. Odd parity is required: the 8 data bits plus the parity bit must contain an odd number of 1s.
- STOP: the stop bit must be 1.
  - Good parity and good stop: deliver the byte to the decoder.
  - Otherwise: discard the byte and pulse `frame_err`.
  - Return to IDLE in either case.
- Timeout: a counter reloads on every `fall`. If it exceeds `TIMEOUT_CYCLES` in any state other than IDLE, return to IDLE and pulse `frame_err`.

Decoder:
- Byte 0xE0 sets the `ext` flag. Byte 0xF0 sets the `brk` flag.
- Any other byte is looked up using the current `ext` state. Both flags then clear.
- Make mapping (`ext`=0): 0x1D→26 (W), 0x1C→4 (A), 0x1B→22 (S), 0x23→7 (D), 0x5A→40 (Enter), 0x29→44 (Space).
- Make of a mapped key:
  - Set `keycode` to the mapped value. The last press wins.
  - Pulse `key_event` with `key_release`=0. A typematic repeat of the held key also pulses.
- Break of a mapped key:
  - Pulse `key_event` with `key_release`=1.
  - Set `keycode` to 0 only if the released key equals the current `keycode`; otherwise leave `keycode` unchanged.
- An unmapped code (make or break) produces no event and leaves `keycode` unchanged.
- A frame error or timeout clears `ext` and `brk`.

## Timing
- Reset values: `keycode`=0, `key_event`=0, `key_release`=0, `frame_err`=0. FSM=IDLE, `ext`=`brk`=0, synchronizers=1, filter=1.
- Reset asserted mid-frame aborts the frame immediately. No pulse is emitted afterwards for that partial frame.
- `fall` occurs 2 + `FILTER_LEN` + 1 cycles after the raw `PS2_CLK` falling edge.
- `keycode`, `key_event` and `key_release` update on the cycle after the stop-bit `fall`.
- `frame_err` asserts on the cycle after the stop-bit `fall`, or on the cycle after the timeout is reached.
- Outputs are registered; `key_release` holds its value between events.
- Multiple simultaneous events cannot occur: exactly one byte is decoded per frame.

## Configuration
- `PS2_ARROW_KEYS_EN` defined: extended arrows alias onto the movement codes.
  - 0xE0 0x75 (up) → 26, 0xE0 0x6B (left) → 4, 0xE0 0x72 (down) → 22, 0xE0 0x74 (right) → 7.
  - Make and break behave exactly as for W, A, S and D.
- `PS2_ARROW_KEYS_EN` undefined: every `ext`-prefixed code is unmapped. It is consumed silently with no event and no `keycode` change.

## Test plan
- Frame 0x1D with good parity → `keycode`=26, one `key_event` with `key_release`=0. Then frames F0 1D → `keycode`=0, `key_event` with `key_release`=1.
- Make 0x1C, then make 0x23, then break 0x1C → `keycode` goes 4, then 7, and stays 7. Three `key_event` pulses.
- Frame 0x1B with a flipped parity bit → `frame_err` pulse, no `key_event`, `keycode` unchanged.
- Stop after the 4th data bit for `TIMEOUT_CYCLES`+1 cycles → `frame_err` pulse, FSM back in IDLE. A following good 0x1B frame → `keycode`=22.
- Frames E0 75, with and without `PS2_ARROW_KEYS_EN` → `keycode`=26 with the macro; no event and `keycode`=0 without it.
- Assert `Reset` low during the 5th data bit while `keycode`=7 → all outputs 0 immediately. A full frame 0x23 after release → `keycode`=7.
